// File: rtl/tone_pkg.sv
// Shared constants and types for the tone voice scheduler: note pitches at
// 12 MHz, the minimum legal half-period and the scheduler state encoding.
package tone_pkg;

    localparam int DEFAULT_HALF_W  = 16;
    localparam int MIN_HALF_PERIOD = 2;

    // Half-periods in clock cycles for C4..B4 at 12 MHz: 6e6 / f, rounded.
    localparam int HP_C4 = 22933;
    localparam int HP_D4 = 20431;
    localparam int HP_E4 = 18202;
    localparam int HP_F4 = 17181;
    localparam int HP_G4 = 15306;
    localparam int HP_A4 = 13636;
    localparam int HP_B4 = 12149;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

endpackage

// File: rtl/tone_divider.sv
// Square-wave divider whose pitch changes are deferred to the next toggle,
// so a new half-period never truncates the phase already in progress.
module tone_divider
    import tone_pkg::*;
#(
    parameter int HALF_W = DEFAULT_HALF_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_now,
    input  logic              load_next,
    input  logic [HALF_W-1:0] hp_in,
    output logic              out
);

    logic [HALF_W-1:0] hp_cur;
    logic [HALF_W-1:0] hp_next;
    logic [HALF_W-1:0] div_cnt;
    logic [HALF_W-1:0] hp_clamped;
    logic              wrap;

    assign hp_clamped = (hp_in < HALF_W'(MIN_HALF_PERIOD)) ? HALF_W'(MIN_HALF_PERIOD) : hp_in;
    assign wrap       = (div_cnt == hp_cur - HALF_W'(1));

    // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hp_cur  <= '0;
            hp_next <= '0;
            div_cnt <= '0;
            out     <= 1'b0;
        end else if (load_now) begin
            hp_cur  <= hp_clamped;
            hp_next <= hp_clamped;
            div_cnt <= '0;
            out     <= 1'b0;
        end else begin
            if (load_next) begin
                hp_next <= hp_clamped;
            end
            if (wrap) begin
                out     <= ~out;
                div_cnt <= '0;
                // A selection landing on the toggle edge takes effect immediately.
                hp_cur  <= load_next ? hp_clamped : hp_next;
            end else begin
                div_cnt <= div_cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_voice_scheduler.sv
// Round-robin time-slicing of one tone divider among N_KEYS held keys; each
// held key owns the voice for SLOT_CYCLES, a released owner hands over at once.
module tone_voice_scheduler
    import tone_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 12000000,
    parameter int N_KEYS          = 4,
    parameter int HALF_W          = DEFAULT_HALF_W,
    parameter int SLOT_CYCLES     = 1200000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_KEYS-1:0]          key_req,
    input  logic [N_KEYS*HALF_W-1:0]   half_period,
    output logic                       out,
    output logic                       active,
    output logic [$clog2(N_KEYS)-1:0]  cur_key
);

    localparam int KEY_W = $clog2(N_KEYS);
    localparam int SC_W  = $clog2(SLOT_CYCLES);

    if (N_KEYS < 2 || N_KEYS > 16 || SLOT_CYCLES < 2 || CLOCK_FREQUENCY < 1) begin : g_param_check
        $error("tone_voice_scheduler: parameter out of range");
    end

    state_e            state;
    logic [SC_W-1:0]   slot_cnt;
    logic [KEY_W-1:0]  first_key;
    logic [KEY_W-1:0]  after_key;
    logic [KEY_W-1:0]  next_key;
    logic [KEY_W-1:0]  sel_key;
    logic              found_after;
    logic              cur_held;
    logic              any_req;
    logic              slot_end;
    logic              load_now;
    logic              rotate;
    logic [HALF_W-1:0] hp_sel;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        first_key   = '0;
        after_key   = '0;
        found_after = 1'b0;
        cur_held    = 1'b0;
        // Scanning downwards leaves the lowest match in each candidate.
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (key_req[i]) begin
                first_key = KEY_W'(i);
                if (KEY_W'(i) > cur_key) begin
                    after_key   = KEY_W'(i);
                    found_after = 1'b1;
                end
                if (KEY_W'(i) == cur_key) begin
                    cur_held = 1'b1;
                end
            end
        end
        // Without a held key above cur_key the rotation wraps to the lowest one.
        next_key = found_after ? after_key : first_key;
    end

    assign any_req  = |key_req;
    assign slot_end = (slot_cnt == SC_W'(SLOT_CYCLES - 1));
    assign load_now = (state == ST_IDLE) && any_req;
    assign rotate   = (state == ST_PLAY) && any_req && (slot_end || !cur_held);
    assign sel_key  = load_now ? first_key : next_key;

    always_comb begin
        hp_sel = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (sel_key == KEY_W'(i)) begin
                hp_sel = half_period[i*HALF_W +: HALF_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !any_req) begin
            state    <= ST_IDLE;
            active   <= 1'b0;
            cur_key  <= '0;
            slot_cnt <= '0;
        end else if (state == ST_IDLE) begin
            state    <= ST_PLAY;
            active   <= 1'b1;
            cur_key  <= first_key;
            slot_cnt <= '0;
        end else if (rotate) begin
            cur_key  <= next_key;
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + SC_W'(1);
        end
    end

    tone_divider #(
        .HALF_W (HALF_W)
    ) u_divider (
        .clock     (clock),
        .reset     (reset),
        .clear     (!any_req),
        .load_now  (load_now),
        .load_next (rotate),
        .hp_in     (hp_sel),
        .out       (out)
    );

endmodule
